tl_ul_reg_bridge: RTL and testbench
===================================

Name: tl_ul_reg_bridge

Overview:
- Downstream consumer of the TileLink-UL A channel produced by the E21 port adapter stage; it also returns that stage's D channel.
- Converts one TL-UL Get/PutFullData/PutPartialData at a time into a simple valid/ready register-port request, waits for the register response, and returns AccessAck/AccessAckData.
- Illegal or out-of-range requests are answered locally with d_denied and never reach the register port.

Parameters:
- BASE, 32'h0000_0000, byte base address of the decoded window (aligned to SIZE).
- SIZE, 32'h0000_1000, window size in bytes, power of two, >= 4.
- SOURCE_W, 1, width of a_source/d_source.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- a_valid  in  1  A-channel valid.
- a_ready  out  1  A-channel ready.
- a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get; others illegal.
- a_param  in  3  must be 0, else illegal.
- a_size  in  2  log2 bytes; 0..2 legal.
- a_source  in  SOURCE_W  request ID, echoed on d_source.
- a_address  in  32  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- a_corrupt  in  1  write data corrupt; Put with corrupt=1 is denied.
- d_valid  out  1  D-channel valid.
- d_ready  in  1  D-channel ready.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_param  out  2  always 0.
- d_size  out  2  echoed a_size.
- d_source  out  SOURCE_W  echoed a_source.
- d_sink  out  1  always 0.
- d_denied  out  1  access refused.
- d_data  out  32  read data.
- d_corrupt  out  1  read data invalid.
- reg_req_valid  out  1  register request valid.
- reg_req_ready  in  1  register request accepted.
- reg_req_write  out  1  1=write, 0=read.
- reg_req_addr  out  32  a_address - BASE, word-aligned (bits[1:0]=0).
- reg_req_wdata  out  32  write data.
- reg_req_wmask  out  4  byte enables (a_mask).
- reg_rsp_valid  in  1  register response, single-cycle pulse.
- reg_rsp_rdata  in  32  read data.
- reg_rsp_error  in  1  slave error.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE. All outputs reset to 0 except a_ready=1; all captured registers reset to 0.
- IDLE: a_ready=1. On a_valid&a_ready, capture opcode, size, source, address, mask and data. Next state is RESP with denied=1 if the request is illegal; otherwise REQ.
- A request is illegal if any of these hold:
  - opcode not in {0,1,4};
  - param!=0;
  - size>2;
  - address not aligned to 2^size;
  - address outside [BASE, BASE+SIZE);
  - PutFull whose mask is not exactly the lanes implied by size/address[1:0];
  - Put with a_corrupt=1.
- REQ: reg_req_valid=1 and all reg_req_* fields stable. Advance to WAIT on reg_req_ready; hold otherwise.
- WAIT: on reg_rsp_valid, capture rdata and error, then go to RESP. reg_rsp_valid outside WAIT is ignored. A response in the same cycle as reg_req_ready (state REQ) is ignored; the register port must respond at least 1 cycle after accept.
- RESP: d_valid=1 and D fields held stable until d_ready; then IDLE.
- d_opcode=1 for Get, 0 for Puts, including denied ones.
- d_denied = illegal | rsp_error.
- d_corrupt = d_denied & Get.
- d_data = captured rdata for a successful Get, 0 otherwise.
- Get requests drive reg_req_wmask equal to captured a_mask; wdata is 0.
- One transaction outstanding. a_ready=0 in REQ/WAIT/RESP, so there is no A/D same-cycle turnaround.
- Minimum latency is A fire (cycle N) → reg_req_valid N+1. With ready=1 and response at N+2, d_valid is at N+3.
- For denied requests, d_valid is at N+1.
- Asynchronous reset mid-transaction: return to IDLE immediately, drop d_valid and reg_req_valid, and send no response for the lost transaction.

Test Plan:
- Get size=2 addr=BASE+0x10, reg_req_ready=1, reg_rsp_rdata=0xDEADBEEF 1 cycle later → reg_req_addr=0x10, write=0; D opcode=1, data=0xDEADBEEF, denied=0, d_valid 3 cycles after A fire.
- PutPartial addr=BASE+0x4, mask=4'b0110, data=0x11223344 → reg_req_write=1, wmask=0110, wdata=0x11223344; D opcode=0, denied=0.
- Get addr=BASE+SIZE (out of range) → no reg_req_valid; d_valid next cycle, opcode=1, denied=1, corrupt=1, data=0.
- PutFull size=2 mask=4'b0111 → denied=1, opcode=0, reg port untouched. Separately, Get size=1 addr=0x1 (misaligned) → denied=1.
- Back-pressure: reg_req_ready low 5 cycles, then d_ready low 3 cycles → request fields and D fields held stable, a_ready=0 throughout; reg_rsp_error=1 → d_denied=1, d_corrupt=1 on Get.
- Deassert reset_n while in WAIT → all valids 0 asynchronously; after release a_ready=1 and a new Get completes normally.

Source files
------------

// File: rtl/tl_ul_reg_bridge_if.sv
// tl_ul_reg_bridge_if: TL-UL A/D channels plus the simple register request/response port.
interface tl_ul_reg_bridge_if #(parameter int SOURCE_W = 1);
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [1:0]          a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [31:0]         a_address;
    logic [3:0]          a_mask;
    logic [31:0]         a_data;
    logic                a_corrupt;
    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    logic [1:0]          d_size;
    logic [SOURCE_W-1:0] d_source;
    logic                d_sink;
    logic                d_denied;
    logic [31:0]         d_data;
    logic                d_corrupt;
    logic                reg_req_valid;
    logic                reg_req_ready;
    logic                reg_req_write;
    logic [31:0]         reg_req_addr;
    logic [31:0]         reg_req_wdata;
    logic [3:0]          reg_req_wmask;
    logic                reg_rsp_valid;
    logic [31:0]         reg_rsp_rdata;
    logic                reg_rsp_error;

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready,
        output reg_req_valid, reg_req_write, reg_req_addr, reg_req_wdata, reg_req_wmask,
        input  reg_req_ready, reg_rsp_valid, reg_rsp_rdata, reg_rsp_error
    );

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready,
        input  reg_req_valid, reg_req_write, reg_req_addr, reg_req_wdata, reg_req_wmask,
        output reg_req_ready, reg_rsp_valid, reg_rsp_rdata, reg_rsp_error
    );
endinterface

// File: rtl/tl_ul_reg_bridge.sv
// tl_ul_reg_bridge: one-at-a-time TL-UL to valid/ready register port bridge with local denial.
module tl_ul_reg_bridge #(
    parameter logic [31:0] BASE     = 32'h0000_0000,
    parameter logic [31:0] SIZE     = 32'h0000_1000,
    parameter int          SOURCE_W = 1
) (
    input logic          clock,
    input logic          reset_n,
    tl_ul_reg_bridge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t              state, state_nx;
    logic [2:0]          op_q;
    logic [1:0]          size_q;
    logic [SOURCE_W-1:0] src_q;
    logic [31:0]         addr_q, data_q, rdata_q;
    logic [3:0]          mask_q;
    logic                den_q, err_q;
    logic [31:0]         off;
    logic [3:0]          lanes;
    logic                misalign, put, illegal, fire, get, req, den;

    assign fire = bus.a_valid && state == IDLE;
    assign get  = op_q == 3'd4;
    assign req  = state == REQ;
    assign den  = den_q || err_q;

    // Legality is decided entirely at A acceptance; denied requests skip the register port.
    always_comb begin
        off      = bus.a_address - BASE;
        lanes    = bus.a_size == 2'd0 ? 4'b0001 << bus.a_address[1:0] :
                   bus.a_size == 2'd1 ? 4'b0011 << {bus.a_address[1], 1'b0} : 4'b1111;
        misalign = bus.a_size == 2'd1 ? bus.a_address[0] :
                   bus.a_size == 2'd2 ? |bus.a_address[1:0] : 1'b0;
        put      = bus.a_opcode == 3'd0 || bus.a_opcode == 3'd1;
        illegal  = !(put || bus.a_opcode == 3'd4) || |bus.a_param || bus.a_size == 2'd3 || misalign ||
                   off >= SIZE || (bus.a_opcode == 3'd0 && bus.a_mask != lanes) || (put && bus.a_corrupt);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fire) state_nx = illegal ? RESP : REQ;
            REQ:     if (bus.reg_req_ready) state_nx = WAIT;
            WAIT:    if (bus.reg_rsp_valid) state_nx = RESP;
            RESP:    if (bus.d_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= '0;
            size_q  <= '0;
            src_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            den_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (fire) begin
                op_q    <= bus.a_opcode;
                size_q  <= bus.a_size;
                src_q   <= bus.a_source;
                addr_q  <= bus.a_address;
                mask_q  <= bus.a_mask;
                data_q  <= bus.a_data;
                den_q   <= illegal;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (state == WAIT && bus.reg_rsp_valid) begin
                rdata_q <= bus.reg_rsp_rdata;
                err_q   <= bus.reg_rsp_error;
            end
        end
    end

    // Register-port fields are forced to 0 outside REQ so idle/reset values are all-zero.
    always_comb begin
        bus.a_ready       = state == IDLE;
        bus.reg_req_valid = req;
        bus.reg_req_write = req && !get;
        bus.reg_req_addr  = req ? (addr_q - BASE) & 32'hFFFF_FFFC : '0;
        bus.reg_req_wdata = req && !get ? data_q : '0;
        bus.reg_req_wmask = req ? mask_q : '0;
        bus.d_valid       = state == RESP;
        bus.d_opcode      = {2'b00, get};
        bus.d_param       = 2'b00;
        bus.d_size        = size_q;
        bus.d_source      = src_q;
        bus.d_sink        = 1'b0;
        bus.d_denied      = den;
        bus.d_corrupt     = den && get;
        bus.d_data        = get && !den ? rdata_q : '0;
    end
endmodule

// File: tb/tb_tl_ul_reg_bridge.sv
// tb_tl_ul_reg_bridge: directed plus randomized transactions checked against a rule-level model.
module tb_tl_ul_reg_bridge;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam logic [31:0] SIZE = 32'h0000_1000;
    localparam int          SW   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tl_ul_reg_bridge_if #(.SOURCE_W(SW)) bus();
    tl_ul_reg_bridge #(.BASE(BASE), .SIZE(SIZE), .SOURCE_W(SW)) dut (.clock(clk), .reset_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lanes_of(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] m;
        int lo;
        m  = '0;
        lo = int'(addr % 4);
        for (int b = 0; b < (1 << size); b++)
            if (lo + b < 4) m[lo + b] = 1'b1;
        return m;
    endfunction

    function automatic bit is_illegal(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                                      input logic [31:0] addr, input logic [3:0] mask, input bit corrupt);
        bit put;
        longint unsigned a, lo, hi;
        put = op == 3'd0 || op == 3'd1;
        a   = {32'd0, addr};
        lo  = {32'd0, BASE};
        hi  = lo + {32'd0, SIZE};
        if (!(put || op == 3'd4)) return 1'b1;
        if (param != 3'd0) return 1'b1;
        if (size > 2'd2) return 1'b1;
        if (addr % (32'd1 << size) != 0) return 1'b1;
        if (a < lo || a >= hi) return 1'b1;
        if (op == 3'd0 && mask != lanes_of(size, addr)) return 1'b1;
        if (put && corrupt) return 1'b1;
        return 1'b0;
    endfunction

    task automatic fire_a(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                          input logic [SW-1:0] src, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, input bit corrupt);
        @(negedge clk);
        check("a_ready_idle", bus.a_ready, 1);
        check("d_valid_idle", bus.d_valid, 0);
        bus.a_valid   = 1'b1;
        bus.a_opcode  = op;
        bus.a_param   = param;
        bus.a_size    = size;
        bus.a_source  = src;
        bus.a_address = addr;
        bus.a_mask    = mask;
        bus.a_data    = data;
        bus.a_corrupt = corrupt;
        @(negedge clk);
        bus.a_valid   = 1'b0;
        bus.a_opcode  = 3'($urandom);
        bus.a_address = $urandom;
        bus.a_mask    = 4'($urandom);
        bus.a_data    = $urandom;
    endtask

    task automatic txn(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                       input logic [SW-1:0] src, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input bit corrupt, input int req_wait, input int rsp_wait,
                       input int d_wait, input logic [31:0] rdata, input bit err, input bit junk);
        bit ill, get, den;
        ill = is_illegal(op, param, size, addr, mask, corrupt);
        get = op == 3'd4;
        fire_a(op, param, size, src, addr, mask, data, corrupt);
        if (ill) begin
            check("req_valid_denied", bus.reg_req_valid, 0);
        end else begin
            for (int i = 0; i <= req_wait; i++) begin
                check("req_valid", bus.reg_req_valid, 1);
                check("req_write", bus.reg_req_write, !get);
                check("req_addr", bus.reg_req_addr, (addr - BASE) & 32'hFFFF_FFFC);
                check("req_wdata", bus.reg_req_wdata, get ? 32'd0 : data);
                check("req_wmask", bus.reg_req_wmask, mask);
                check("a_ready_req", bus.a_ready, 0);
                check("d_valid_req", bus.d_valid, 0);
                if (i == req_wait) begin
                    bus.reg_req_ready = 1'b1;
                    if (junk) begin
                        bus.reg_rsp_valid = 1'b1;
                        bus.reg_rsp_rdata = ~rdata;
                        bus.reg_rsp_error = ~err;
                    end
                end
                @(negedge clk);
            end
            bus.reg_req_ready = 1'b0;
            bus.reg_rsp_valid = 1'b0;
            for (int i = 0; i <= rsp_wait; i++) begin
                check("req_valid_wait", bus.reg_req_valid, 0);
                check("d_valid_wait", bus.d_valid, 0);
                check("a_ready_wait", bus.a_ready, 0);
                if (i == rsp_wait) begin
                    bus.reg_rsp_valid = 1'b1;
                    bus.reg_rsp_rdata = rdata;
                    bus.reg_rsp_error = err;
                end
                @(negedge clk);
            end
            bus.reg_rsp_valid = 1'b0;
            bus.reg_rsp_rdata = $urandom;
            bus.reg_rsp_error = 1'b0;
        end
        den = ill || err;
        for (int i = 0; i <= d_wait; i++) begin
            check("d_valid", bus.d_valid, 1);
            check("a_ready_resp", bus.a_ready, 0);
            check("req_valid_resp", bus.reg_req_valid, 0);
            check("d_opcode", bus.d_opcode, get ? 3'd1 : 3'd0);
            check("d_param", bus.d_param, 0);
            check("d_size", bus.d_size, size);
            check("d_source", bus.d_source, src);
            check("d_sink", bus.d_sink, 0);
            check("d_denied", bus.d_denied, den);
            check("d_corrupt", bus.d_corrupt, den && get);
            check("d_data", bus.d_data, (get && !den) ? rdata : 32'd0);
            if (i == d_wait) bus.d_ready = 1'b1;
            @(negedge clk);
        end
        bus.d_ready = 1'b0;
        check("d_valid_done", bus.d_valid, 0);
        check("a_ready_done", bus.a_ready, 1);
    endtask

    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_d_valid"}, bus.d_valid, 0);
        check({tag, "_rst_req_valid"}, bus.reg_req_valid, 0);
        check({tag, "_rst_a_ready"}, bus.a_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.reg_rsp_valid = 1'b1;
        bus.reg_rsp_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.reg_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check({tag, "_post_d_valid"}, bus.d_valid, 0);
            check({tag, "_post_a_ready"}, bus.a_ready, 1);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [2:0]  op, param;
        logic [1:0]  size;
        logic [31:0] off, addr;
        logic [3:0]  mask;
        int          r;
        bus.a_valid = 0; bus.a_opcode = 0; bus.a_param = 0; bus.a_size = 0; bus.a_source = 0;
        bus.a_address = 0; bus.a_mask = 0; bus.a_data = 0; bus.a_corrupt = 0; bus.d_ready = 0;
        bus.reg_req_ready = 0; bus.reg_rsp_valid = 0; bus.reg_rsp_rdata = 0; bus.reg_rsp_error = 0;
        #23;
        check("reset_a_ready", bus.a_ready, 1);
        check("reset_d_valid", bus.d_valid, 0);
        check("reset_req_valid", bus.reg_req_valid, 0);
        check("reset_req_write", bus.reg_req_write, 0);
        check("reset_req_addr", bus.reg_req_addr, 0);
        check("reset_d_denied", bus.d_denied, 0);
        check("reset_d_data", bus.d_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        txn(3'd4, 0, 2, 1, BASE + 32'h10, 4'hF, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0);
        txn(3'd1, 0, 2, 2, BASE + 32'h4, 4'b0110, 32'h11223344, 0, 0, 0, 0, 0, 0, 0);
        txn(3'd4, 0, 2, 3, BASE + SIZE, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        txn(3'd0, 0, 2, 0, BASE, 4'b0111, 32'hCAFE0000, 0, 0, 0, 0, 0, 0, 0);
        txn(3'd4, 0, 1, 1, BASE + 32'h1, 4'h3, 0, 0, 0, 0, 0, 0, 0, 0);
        txn(3'd4, 0, 2, 2, BASE + 32'hFFC, 4'hF, 0, 0, 5, 2, 3, 32'h5555AAAA, 1, 1);
        txn(3'd0, 0, 0, 1, BASE + 32'h3, 4'b1000, 32'h77000000, 0, 0, 0, 0, 0, 0, 1);
        txn(3'd0, 0, 2, 0, BASE + 32'h8, 4'hF, 32'h1, 1, 0, 0, 0, 0, 0, 0);
        txn(3'd4, 3'd1, 2, 0, BASE + 32'h8, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        txn(3'd2, 0, 2, 0, BASE + 32'h8, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        txn(3'd4, 0, 2, 0, BASE - 32'h4, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        txn(3'd4, 0, 3, 0, BASE, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);

        fire_a(3'd4, 0, 2, 1, BASE + 32'h20, 4'hF, 0, 0);
        check("abort_req_valid_before", bus.reg_req_valid, 1);
        reset_pulse("req");
        fire_a(3'd4, 0, 2, 1, BASE + 32'h20, 4'hF, 0, 0);
        bus.reg_req_ready = 1'b1;
        @(negedge clk);
        bus.reg_req_ready = 1'b0;
        check("abort_wait_req_valid", bus.reg_req_valid, 0);
        reset_pulse("wait");
        fire_a(3'd4, 0, 2, 1, BASE + SIZE + 32'h20, 4'hF, 0, 0);
        check("abort_d_valid_before", bus.d_valid, 1);
        reset_pulse("resp");
        txn(3'd4, 0, 2, 2, BASE + 32'h24, 4'hF, 0, 0, 0, 0, 0, 32'h0BADF00D, 0, 0);

        for (int k = 0; k < 80; k++) begin
            r     = $urandom % 8;
            op    = r < 3 ? 3'd4 : r < 5 ? 3'd0 : r < 7 ? 3'd1 : 3'($urandom);
            param = ($urandom % 16 == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            size  = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            off   = $urandom % SIZE;
            if ($urandom % 8 != 0) off = off & ~((32'd1 << size) - 1);
            r     = $urandom % 10;
            addr  = r == 0 ? BASE + SIZE + off : r == 1 ? BASE - 32'd4 - off : BASE + off;
            mask  = (op == 3'd0 && $urandom % 8 != 0) ? lanes_of(size, addr) : 4'($urandom);
            txn(op, param, size, SW'($urandom), addr, mask, $urandom, $urandom % 10 == 0,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, $urandom % 6 == 0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
